mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one unified memory port between instruction fetch (I) and data load/store (D) for the upcoming multi-cycle core.
- Sits between the fetch/LSU requesters and the unified memory.
- Single outstanding transaction; data-first priority with a fetch anti-starvation counter.
- Response timeout and a sticky protocol-error flag.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- STARVE_MAX, 4, consecutive lost conflicts after which fetch wins the next conflict (≥1).
- TIMEOUT, 16, max cycles in WAIT before forced completion (≥2).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  combinational grant pulse
- if_rvalid  out  1  registered response pulse
- if_rdata  out  DATA_WIDTH  fetched instruction
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store
- d_op  in  3  mem_op code, passed through unchanged
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_gnt  out  1  combinational grant pulse
- d_rvalid  out  1  registered completion pulse (loads and stores)
- d_rdata  out  DATA_WIDTH  load data; 0 for stores
- mem_req  out  1  request to memory
- mem_we  out  1  write enable
- mem_op  out  3  access size/sign
- mem_addr  out  ADDR_WIDTH  address
- mem_wdata  out  DATA_WIDTH  write data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  DATA_WIDTH  response data
- err  out  1  sticky error flag

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, owner=I, starve_cnt=0, wait_cnt=0, err=0.
  - Latched request fields, if_rdata and d_rdata cleared to 0.
  - All registered outputs are 0.
  - Reset mid-transaction abandons it; no response is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant decided combinationally; at most one of if_gnt/d_gnt high; gnt=0 outside IDLE.
  - Only d_req → d_gnt.
  - Only if_req → if_gnt.
  - Both high:
    - If starve_cnt==STARVE_MAX → if_gnt and starve_cnt←0.
    - Otherwise → d_gnt and starve_cnt←starve_cnt+1.
  - Any uncontested if_gnt also sets starve_cnt←0.
  - On a grant edge: latch owner, addr, we, op, wdata; go to ISSUE.
  - Fetch latches we=0, op=3'b010 (word), wdata=0.
- ISSUE:
  - mem_req=1; mem_* driven from the latches and stable while waiting.
  - mem_ready=1 → WAIT with wait_cnt←0; otherwise hold.
  - No timeout applies in ISSUE.
- WAIT:
  - mem_req=0; wait_cnt increments each cycle.
  - mem_rvalid=1 → capture mem_rdata into the owner's rdata (d_rdata←0 if store); go to RESP.
  - wait_cnt==TIMEOUT-1 with no mem_rvalid → owner rdata←0, err←1, go to RESP.
- RESP:
  - Owner's rvalid=1 for exactly one cycle; rdata holds until the next response to that requester.
  - Go to IDLE.
- mem_* outputs outside ISSUE: mem_req=0; mem_addr/we/op/wdata hold their latched values; mem_we is gated to 0 when mem_req=0.
- Minimum turnaround: gnt at cycle N, mem_req at N+1 (with ready), WAIT at N+2, mem_rvalid at N+2, rvalid at N+3, next gnt at N+4. One transaction per 4 cycles.
- Protocol error: mem_rvalid=1 in any state other than WAIT sets err=1; the data is ignored and the state is unaffected.
- err clears only on reset.
- Requester deasserting req before gnt is legal; the request is simply never granted.
- starve_cnt saturates at STARVE_MAX and never wraps.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; mem_ready=1 immediately; mem_rvalid with rdata=0x00500093 one cycle after accept → if_gnt at cycle 0, mem_req at cycle 1, if_rvalid=1 and if_rdata=0x00500093 at cycle 3; d_rvalid stays 0.
- Store: d_req=1, d_we=1, d_op=3'b010, d_addr=0x2000, d_wdata=0xDEADBEEF; mem_ready delayed 3 cycles → mem_req held high 4 cycles with stable mem_addr/mem_wdata/mem_we=1; d_rvalid pulses once with d_rdata=0.
- Contention with STARVE_MAX=4: if_req and d_req both held high continuously → grant order D,D,D,D,I,D,D,D,D,I; never two consecutive I grants while D is requesting.
- Timeout with TIMEOUT=16: accept load at 0x3000, never assert mem_rvalid → d_rvalid exactly 16 cycles after entering WAIT, d_rdata=0, err=1 and remains 1 through later good transactions.
- Spurious response: mem_rvalid=1 while IDLE → err=1, no rvalid pulse on either requester, next fetch completes normally.
- Reset mid-operation: rst_n=0 for one cycle during WAIT → next cycle state IDLE, all outputs 0, a late mem_rvalid is ignored but flags err; a subsequent fetch to 0x0 completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the unified memory port arbiter.
// Carries the fetch requester, the load/store requester and the memory-side
// handshake. The arbiter uses the slave view. The environment (requesters
// plus memory) uses the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  // Instruction fetch requester
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  // Data load/store requester
  logic                  d_req;
  logic                  d_we;
  logic [2:0]            d_op;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  // Unified memory port
  logic                  mem_req;
  logic                  mem_we;
  logic [2:0]            mem_op;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Sticky protocol / timeout error
  logic                  err;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_op, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_op, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output err
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_op, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_op, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  err
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter.
// Shares one memory port between instruction fetch (I) and data load/store
// (D). Only one transaction is in flight at a time. Data wins conflicts
// unless fetch has already lost STARVE_MAX conflicts in a row. A response
// that never arrives is force-completed after TIMEOUT cycles in WAIT. Any
// response seen outside WAIT is flagged as a protocol error. Both the
// timeout and the protocol error raise a sticky err flag.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  // Fetches are always plain word reads.
  localparam logic [2:0] OP_WORD = 3'b010;

  state_e                state_q;
  state_e                state_d;
  owner_e                owner_q;
  logic [STARVE_W-1:0]   starve_q;
  logic [STARVE_W-1:0]   starve_d;
  logic [WAIT_W-1:0]     wait_q;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;
  logic                  err_q;

  logic                  if_gnt_c;
  logic                  d_gnt_c;
  logic                  resp_hit;
  logic                  timeout_hit;
  logic                  spurious_hit;

  // In WAIT, a real response takes priority over the timeout.
  assign resp_hit     = (state_q == ST_WAIT) && bus.mem_rvalid;
  assign timeout_hit  = (state_q == ST_WAIT) && !bus.mem_rvalid && (wait_q == WAIT_LAST);
  assign spurious_hit = (state_q != ST_WAIT) && bus.mem_rvalid;

  // Grant decision, starvation bookkeeping and next-state selection.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if_gnt_c = 1'b0;
    d_gnt_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.if_req && bus.d_req) begin
          // Fetch wins only once it has lost STARVE_MAX conflicts in a row.
          // The counter therefore never moves past STARVE_LIMIT.
          if (starve_q == STARVE_LIMIT) begin
            if_gnt_c = 1'b1;
            starve_d = '0;
          end else begin
            d_gnt_c  = 1'b1;
            starve_d = starve_q + STARVE_W'(1);
          end
        end else if (bus.d_req) begin
          d_gnt_c = 1'b1;
        end else if (bus.if_req) begin
          if_gnt_c = 1'b1;
          starve_d = '0;
        end

        if (if_gnt_c || d_gnt_c) begin
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (bus.mem_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (resp_hit || timeout_hit) begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register and starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Capture the winning request so mem_* stay stable while the requester moves on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OWN_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      op_q    <= '0;
      wdata_q <= '0;
    end else if (d_gnt_c) begin
      owner_q <= OWN_D;
      addr_q  <= bus.d_addr;
      we_q    <= bus.d_we;
      op_q    <= bus.d_op;
      wdata_q <= bus.d_wdata;
    end else if (if_gnt_c) begin
      owner_q <= OWN_I;
      addr_q  <= bus.if_addr;
      we_q    <= 1'b0;
      op_q    <= OP_WORD;
      wdata_q <= '0;
    end
  end

  // Response-wait counter: restarted on accept, advanced while waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else if ((state_q == ST_ISSUE) && bus.mem_ready) begin
      wait_q <= '0;
    end else if ((state_q == ST_WAIT) && (wait_q != WAIT_LAST)) begin
      wait_q <= wait_q + WAIT_W'(1);
    end
  end

  // Per-requester read data: updated only on that requester's completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (resp_hit) begin
      if (owner_q == OWN_D) begin
        d_rdata_q <= we_q ? '0 : bus.mem_rdata;
      end else begin
        if_rdata_q <= bus.mem_rdata;
      end
    end else if (timeout_hit) begin
      if (owner_q == OWN_D) begin
        d_rdata_q <= '0;
      end else begin
        if_rdata_q <= '0;
      end
    end
  end

  // Sticky error: set by timeouts and stray responses, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (timeout_hit || spurious_hit) begin
      err_q <= 1'b1;
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.d_gnt     = d_gnt_c;

  assign bus.if_rvalid = (state_q == ST_RESP) && (owner_q == OWN_I);
  assign bus.d_rvalid  = (state_q == ST_RESP) && (owner_q == OWN_D);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

  assign bus.mem_req   = (state_q == ST_ISSUE);
  assign bus.mem_we    = (state_q == ST_ISSUE) && we_q;
  assign bus.mem_op    = op_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.err       = err_q;

endmodule
